// File: rtl/seq_det_pkg.sv
// Shared types and sizing helpers for the sequence-detector controller.
package seq_det_pkg;

    typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_t;

    localparam int unsigned DEF_WORD_W = 16;

    function automatic int unsigned cnt_width(input int unsigned word_w);
        return $clog2(word_w + 1);
    endfunction

endpackage

// File: rtl/seq_piso.sv
// Parallel-in serial-out register; the MSB is presented first.
module seq_piso #(
    parameter int unsigned WORD_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] din,
    output logic              msb
);

    logic [WORD_W-1:0] sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= {sr[WORD_W-2:0], 1'b0};
        end
    end

    assign msb = sr[WORD_W-1];

endmodule

// File: rtl/seq_det_ctrl.sv
// Feeds a word MSB-first into an external Moore detector, then reports the
// hit count and the 1-based position of the first hit.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int unsigned WORD_W = DEF_WORD_W,
    parameter int unsigned CNT_W  = cnt_width(WORD_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_word,
    input  logic              abort,
    output logic              det_clr,
    output logic              det_in,
    input  logic              det_y,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  first_pos
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic             load;
    logic             shift;
    logic             piso_msb;
    logic             hit;

    assign load  = (state == IDLE) && s_valid;
    assign shift = ((state == CLEAR) && !abort) || (state == SHIFT);
    // bit_cnt equals the sample index k; the first SHIFT cycle (bit_cnt==0)
    // still shows the just-cleared detector and is skipped.
    assign hit   = det_y && !abort &&
                   (((state == SHIFT) && (bit_cnt != '0)) || (state == DRAIN));

    seq_piso #(
        .WORD_W (WORD_W)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (s_word),
        .msb   (piso_msb)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            s_ready   <= 1'b1;
            m_valid   <= 1'b0;
            det_clr   <= 1'b0;
            det_in    <= 1'b0;
            hit_cnt   <= '0;
            first_pos <= '0;
            bit_cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (s_valid) begin
                        state     <= CLEAR;
                        s_ready   <= 1'b0;
                        det_clr   <= 1'b1;
                        det_in    <= 1'b0;
                        hit_cnt   <= '0;
                        first_pos <= '0;
                        bit_cnt   <= '0;
                    end
                end
                CLEAR: begin
                    det_clr <= 1'b0;
                    if (abort) begin
                        state   <= IDLE;
                        s_ready <= 1'b1;
                        det_in  <= 1'b0;
                    end else begin
                        state  <= SHIFT;
                        det_in <= piso_msb;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state   <= IDLE;
                        s_ready <= 1'b1;
                        det_in  <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state  <= DRAIN;
                            det_in <= 1'b0;
                        end else begin
                            det_in <= piso_msb;
                        end
                    end
                end
                DRAIN: begin
                    det_in <= 1'b0;
                    if (abort) begin
                        state   <= IDLE;
                        s_ready <= 1'b1;
                    end else begin
                        state   <= DONE;
                        m_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (m_ready) begin
                        state   <= IDLE;
                        m_valid <= 1'b0;
                        s_ready <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    s_ready <= 1'b1;
                    m_valid <= 1'b0;
                    det_clr <= 1'b0;
                    det_in  <= 1'b0;
                end
            endcase

            if (hit) begin
                hit_cnt <= hit_cnt + 1'b1;
                if (first_pos == '0) begin
                    first_pos <= bit_cnt;
                end
            end
        end
    end

endmodule
